// File: rtl/defines_package.sv
// Shared constants and types for the wireframe display path.
//   WIDTH / HEIGHT        : default frame geometry in pixels
//   WIREFRAME_ADDR_SIZE   : wireframe SRAM address width
//   SCANOUT_FIFO_DEPTH    : pixel FIFO depth inside wireframe_scanout
//   scanout_state_t       : scanout FSM state encoding
package defines_package;

  localparam int WIDTH               = 640;
  localparam int HEIGHT              = 480;
  localparam int WIREFRAME_ADDR_SIZE = 19;
  localparam int SCANOUT_FIFO_DEPTH  = 4;

  typedef enum logic [1:0] {
    SCAN_IDLE  = 2'd0,
    SCAN_SCAN  = 2'd1,
    SCAN_DRAIN = 2'd2,
    SCAN_SWAP  = 2'd3
  } scanout_state_t;

endpackage

// File: rtl/scanout_fifo.sv
// Small synchronous FIFO holding {data, eol, eof} pixel entries.
//   clk, n_rst : clock, asynchronous active-low reset
//   push       : write push_data this cycle (ignored when full and not popping)
//   push_data  : 3-bit entry {data, eol, eof}
//   pop        : discard head entry this cycle (ignored when empty)
//   head       : current head entry
//   count      : number of stored entries (0..SCANOUT_FIFO_DEPTH)
module scanout_fifo
  import defines_package::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       push,
  input  logic [2:0] push_data,
  input  logic       pop,
  output logic [2:0] head,
  output logic [2:0] count
);

  localparam int PTR_W = $clog2(SCANOUT_FIFO_DEPTH);

  logic [2:0]       mem [SCANOUT_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & (count != 3'd0);
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign do_push = push & ((count != 3'(SCANOUT_FIFO_DEPTH)) | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < SCANOUT_FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + 3'(do_push) - 3'(do_pop);
    end
  end

endmodule

// File: rtl/wireframe_scanout.sv
// Read-side master for the double-buffered wireframe SRAM.
// Sweeps the front buffer in raster order, absorbs the one-cycle SRAM read
// latency through a small FIFO and streams one bit per pixel over valid/ready.
// Pulses flip at a frame boundary when the renderer has a finished frame.
//   clk, n_rst   : clock, asynchronous active-low reset
//   enable       : scan while high; stops at the next frame boundary when low
//   render_done  : pulse, back buffer holds a complete frame
//   read_addr    : SRAM read address (registered)
//   sram_data    : SRAM data, valid one cycle after read_addr
//   flip         : one-cycle buffer swap pulse
//   pix_valid / pix_ready / pix_data / pix_eol / pix_eof : pixel stream
//   busy         : FSM not idle
//
// state | meaning
// IDLE  | no reads issued, waiting for enable
// SCAN  | issuing reads for the current frame
// DRAIN | capture the final pixel, no read issued
// SWAP  | flip if a frame is pending, rewind address
module wireframe_scanout
  import defines_package::*;
#(
  parameter int FB_W   = WIDTH,
  parameter int FB_H   = HEIGHT,
  parameter int ADDR_W = WIREFRAME_ADDR_SIZE
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              enable,
  input  logic              render_done,
  output logic [ADDR_W-1:0] read_addr,
  input  logic              sram_data,
  output logic              flip,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_data,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = SCAN_IDLE;
  localparam logic [1:0] S_SCAN  = SCAN_SCAN;
  localparam logic [1:0] S_DRAIN = SCAN_DRAIN;
  localparam logic [1:0] S_SWAP  = SCAN_SWAP;

  localparam int              XW        = (FB_W > 1) ? $clog2(FB_W) : 1;
  localparam logic [XW-1:0]   LAST_X    = XW'(FB_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

  logic [1:0]    state;
  logic [XW-1:0] x_cnt;
  logic          inflight;
  logic          tag_eol;
  logic          tag_eof;
  logic          flip_pending;
  logic [2:0]    fifo_count;
  logic [2:0]    fifo_head;
  logic          issue;
  logic          issue_eol;
  logic          issue_eof;
  logic          push;
  logic          pop;

  // Buffered plus in-flight pixels never exceed 3, so a 4-deep FIFO cannot overflow.
  assign issue     = (state == S_SCAN) &&
                     (({1'b0, fifo_count} + {3'b000, inflight}) <= 4'd2);
  assign issue_eol = (x_cnt == LAST_X);
  assign issue_eof = (read_addr == LAST_ADDR);

  // Nothing is in flight during SWAP; the state term keeps stray data out.
  assign push = inflight && (state != S_SWAP);
  assign pop  = pix_valid & pix_ready;

  scanout_fifo u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (push),
    .push_data ({sram_data, tag_eol, tag_eof}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign pix_valid = (fifo_count != 3'd0);
  assign pix_data  = pix_valid & fifo_head[2];
  assign pix_eol   = pix_valid & fifo_head[1];
  assign pix_eof   = pix_valid & fifo_head[0];
  assign flip      = (state == S_SWAP) & flip_pending;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= S_IDLE;
      read_addr    <= '0;
      x_cnt        <= '0;
      inflight     <= 1'b0;
      tag_eol      <= 1'b0;
      tag_eof      <= 1'b0;
      flip_pending <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        tag_eol <= issue_eol;
        tag_eof <= issue_eof;
      end
      // A request landing on the clearing SWAP counts toward the next frame.
      flip_pending <= render_done | (flip_pending & (state != S_SWAP));

      case (state)
        S_IDLE: begin
          read_addr <= '0;
          x_cnt     <= '0;
          if (enable) state <= S_SCAN;
        end
        S_SCAN: begin
          if (issue) begin
            if (issue_eof) begin
              state <= S_DRAIN;
            end else begin
              read_addr <= read_addr + ADDR_W'(1);
              x_cnt     <= issue_eol ? '0 : x_cnt + XW'(1);
            end
          end
        end
        S_DRAIN: state <= S_SWAP;
        S_SWAP: begin
          read_addr <= '0;
          x_cnt     <= '0;
          state     <= enable ? S_SCAN : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wireframe_scanout.sv
module tb_wireframe_scanout;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       enable;
  logic       render_done;
  logic [2:0] read_addr;
  logic       sram_data;
  logic       flip;
  logic       pix_valid;
  logic       pix_ready;
  logic       pix_data;
  logic       pix_eol;
  logic       pix_eof;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wireframe_scanout #(.FB_W(4), .FB_H(2), .ADDR_W(3)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .enable      (enable),
    .render_done (render_done),
    .read_addr   (read_addr),
    .sram_data   (sram_data),
    .flip        (flip),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .pix_eol     (pix_eol),
    .pix_eof     (pix_eof),
    .busy        (busy)
  );

  // Double-buffered SRAM model: pixel i of a buffer is bit i of its pattern.
  logic [7:0] pat0 = 8'hB2;
  logic [7:0] pat1 = 8'h5C;
  logic       sel  = 1'b0;

  always @(posedge clk) begin
    if (flip) sel <= ~sel;
    sram_data <= sel ? pat1[read_addr] : pat0[read_addr];
  end

  // Monitor: accepted pixels, flip pulses, hold stability, FIFO occupancy.
  int         cyc = 0;
  logic [2:0] pq[$];
  int         pcyc[$];
  int         flips = 0;
  int         first_flip_cyc = -1;
  int         stab_err = 0;
  int         max_cnt = 0;
  logic       hold_prev = 1'b0;
  logic [2:0] prev_pix = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!n_rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && !(pix_valid && ({pix_data, pix_eol, pix_eof} == prev_pix)))
        stab_err++;
      hold_prev = pix_valid && !pix_ready;
      prev_pix  = {pix_data, pix_eol, pix_eof};
      if (pix_valid && pix_ready) begin
        pq.push_back({pix_data, pix_eol, pix_eof});
        pcyc.push_back(cyc);
      end
      if (flip) begin
        flips++;
        if (first_flip_cyc < 0) first_flip_cyc = cyc;
      end
      if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_pix(input int n, input int budget);
    int k = 0;
    while (pq.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("wait_pix", int'(pq.size() >= n), 1);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [7:0] pat);
    logic [2:0] e;
    for (int i = 0; i < 8; i++) begin
      e = (base + i < pq.size()) ? pq[base + i] : 3'bxxx;
      check({tag, "_data"}, int'(e[2]), int'(pat[i]));
      check({tag, "_eol"},  int'(e[1]), int'(i == 3 || i == 7));
      check({tag, "_eof"},  int'(e[0]), int'(i == 7));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_addr"},  int'(read_addr), 0);
    check({tag, "_flip"},  int'(flip), 0);
    check({tag, "_valid"}, int'(pix_valid), 0);
    check({tag, "_data"},  int'(pix_data), 0);
    check({tag, "_eol"},   int'(pix_eol), 0);
    check({tag, "_eof"},   int'(pix_eof), 0);
    check({tag, "_busy"},  int'(busy), 0);
  endtask

  initial begin
    logic swap_seen;
    n_rst       = 1'b0;
    enable      = 1'b0;
    pix_ready   = 1'b1;
    render_done = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(posedge clk); #1;
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", int'(busy), 0);
    check("idle_addr", int'(read_addr), 0);

    // Frame 1: latency, raster order, tags; render_done mid-frame
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("c1_busy", int'(busy), 1);
    check("c1_addr", int'(read_addr), 0);
    check("c1_valid", int'(pix_valid), 0);
    @(negedge clk);
    check("c2_valid", int'(pix_valid), 0);
    @(negedge clk);
    check("c3_valid", int'(pix_valid), 1);
    check("c3_data", int'(pix_data), int'(pat0[0]));
    @(posedge clk); #1;
    render_done = 1'b1;
    @(posedge clk); #1;
    render_done = 1'b0;
    check("f1_noflip_yet", flips, 0);
    wait_pix(8, 40);
    check_frame("f1", 0, pat0);
    for (int i = 1; i < 8; i++)
      check("f1_consecutive", (i < pcyc.size()) ? pcyc[i] - pcyc[0] : -1, i);
    // SWAP coincides with the cycle presenting the last pixel at full rate
    @(posedge clk);
    check("f1_flip_count", flips, 1);
    check("f1_flip_in_swap", first_flip_cyc, (pcyc.size() > 7) ? pcyc[7] : -2);

    // Frame 2 shows the newly written buffer; frames 2,3 without render_done
    wait_pix(16, 40);
    check_frame("f2", 8, pat1);
    check("f2_period", (pcyc.size() > 8) ? pcyc[8] - pcyc[0] : -1, 10);
    wait_pix(24, 40);
    check_frame("f3", 16, pat1);
    for (int i = 0; i < 8; i++)
      check("f3_eq_f2", int'(pq[16 + i]), int'(pq[8 + i]));
    check("f3_flip_count", flips, 1);

    // Frame 4: toggling backpressure, render_done mid-frame and again in SWAP
    swap_seen = 1'b0;
    for (int i = 0; i < 400 && !(pq.size() >= 32 && swap_seen); i++) begin
      @(posedge clk); #1;
      pix_ready   = ~pix_ready;
      render_done = (i == 6) || flip;
      if (flip) swap_seen = 1'b1;
    end
    @(posedge clk); #1;
    render_done = 1'b0;
    pix_ready   = 1'b1;
    check("f4_swap_seen", int'(swap_seen), 1);
    check_frame("f4", 24, pat1);
    check("f4_flip_count", flips, 2);
    check("f4_pending_kept", int'(dut.flip_pending), 1);
    check("f4_hold_stable", stab_err, 0);
    check("f4_fifo_max", int'(max_cnt <= 3), 1);

    // Frame 5: second flip from the request made during SWAP
    wait_pix(40, 60);
    check_frame("f5", 32, pat0);
    wait_pix(43, 40);
    check("f5_flip_count", flips, 3);
    check("f5_pending_clear", int'(dut.flip_pending), 0);

    // Reset mid-frame 6, then restart from address 0
    @(posedge clk); #2;
    n_rst = 1'b0;
    #1;
    check_outputs_zero("midrst");
    @(posedge clk); #1;
    n_rst = 1'b1;
    pq.delete();
    pcyc.delete();
    @(posedge clk);
    @(negedge clk);
    check("restart_busy", int'(busy), 1);
    check("restart_addr", int'(read_addr), 0);
    wait_pix(8, 40);
    check_frame("restart", 0, pat1);
    check("restart_flips", flips, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
